goodie_field: RTL and testbench

//  Parametrised multi-slot goodie generator for the playfield. Holds NUM_GOODIES independent collectibles, each

---
 rtl/goodie_field.sv | 169 ++++++++++++++++
 tb/tb_goodie_field.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/goodie_field.sv
// Multi-slot collectible generator: each slot scrolls left, bobs between vertical bounds,
// respawns at an LFSR-chosen height after a wait, and despawns for a while when collected.
module goodie_field #(
  parameter int          NUM_GOODIES   = 2,
  parameter int          TICK_DIV      = 10000,
  parameter int          SPEED_X       = 5,
  parameter int          SPEED_Y       = 2,
  parameter int          SCREEN_W      = 640,
  parameter int          Y_MIN         = 40,
  parameter int          Y_SPAN_LOG2   = 8,
  parameter int          RESPAWN_TICKS = 20,
  parameter int          HIT_TICKS     = 4,
  parameter int          STAGGER_TICKS = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     initialize,
  input  logic                     enable,
  input  logic [NUM_GOODIES-1:0]   collect,
  output logic [11*NUM_GOODIES-1:0] goodie_x,
  output logic [10*NUM_GOODIES-1:0] goodie_y,
  output logic [NUM_GOODIES-1:0]   goodie_act,
  output logic                     score_inc
);

  localparam int TICK_W      = $clog2(TICK_DIV);
  localparam int STAGGER_MAX = 1 + (NUM_GOODIES - 1) * STAGGER_TICKS;
  localparam int WAIT_MAX2   = (RESPAWN_TICKS > HIT_TICKS) ? RESPAWN_TICKS : HIT_TICKS;
  localparam int WAIT_MAX    = (STAGGER_MAX > WAIT_MAX2) ? STAGGER_MAX : WAIT_MAX2;
  localparam int WAIT_W      = $clog2(WAIT_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [10:0]       X_SPAWN     = 11'(SCREEN_W);
  localparam logic [10:0]       X_STEP      = 11'(SPEED_X);
  localparam logic [9:0]        Y_LO        = 10'(Y_MIN);
  localparam logic [9:0]        Y_HI        = 10'(Y_MIN + (2 ** Y_SPAN_LOG2) - 1);
  localparam logic [9:0]        Y_STEP      = 10'(SPEED_Y);
  localparam logic [9:0]        Y_LO_TURN   = 10'(Y_MIN + SPEED_Y);
  localparam logic [9:0]        Y_HI_TURN   = 10'(Y_MIN + (2 ** Y_SPAN_LOG2) - 1 - SPEED_Y);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_RESP   = WAIT_W'(RESPAWN_TICKS);
  localparam logic [WAIT_W-1:0] WAIT_HIT    = WAIT_W'(HIT_TICKS);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_MOVE = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  state_t              state    [NUM_GOODIES];
  logic [10:0]         pos_x    [NUM_GOODIES];
  logic [9:0]          pos_y    [NUM_GOODIES];
  logic                dir_up   [NUM_GOODIES];
  logic [WAIT_W-1:0]   wait_cnt [NUM_GOODIES];
  logic [TICK_W-1:0]   tick_cnt;
  logic [15:0]         lfsr;
  logic                tick;
  logic                any_hit;

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero state never maps to zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign tick = (tick_cnt == TICK_LAST) && enable;

  // Any moving slot being collected this cycle produces a single score pulse.
  always_comb begin
    any_hit = 1'b0;
    for (int i = 0; i < NUM_GOODIES; i++) begin
      any_hit = any_hit | ((state[i] == ST_MOVE) & collect[i]);
    end
  end

  // Tick divider, LFSR and all slot state machines.
  always_ff @(posedge clk) begin
    if (initialize) begin
      tick_cnt  <= '0;
      lfsr      <= LFSR_SEED;
      score_inc <= 1'b0;
      for (int i = 0; i < NUM_GOODIES; i++) begin
        state[i]      <= ST_WAIT;
        pos_x[i]      <= X_SPAWN;
        pos_y[i]      <= Y_LO;
        dir_up[i]     <= 1'b0;
        wait_cnt[i]   <= WAIT_W'(1 + i * STAGGER_TICKS);
        goodie_act[i] <= 1'b0;
      end
    end else begin
      if (enable) begin
        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        lfsr     <= lfsr_step(lfsr);
      end
      score_inc <= any_hit;
      for (int i = 0; i < NUM_GOODIES; i++) begin
        case (state[i])
          ST_WAIT: begin
            if (tick) begin
              if (wait_cnt[i] == WAIT_ONE) begin
                state[i]      <= ST_MOVE;
                goodie_act[i] <= 1'b1;
                pos_x[i]      <= X_SPAWN;
                pos_y[i]      <= Y_LO + 10'(lfsr[Y_SPAN_LOG2-1:0]);
                dir_up[i]     <= lfsr[15];
              end else begin
                wait_cnt[i] <= wait_cnt[i] - WAIT_ONE;
              end
            end
          end
          ST_MOVE: begin
            // Collection is not gated by enable and pre-empts a same-cycle move.
            if (collect[i]) begin
              state[i]      <= ST_HIT;
              goodie_act[i] <= 1'b0;
              wait_cnt[i]   <= WAIT_HIT;
            end else if (tick) begin
              if (pos_x[i] < X_STEP) begin
                state[i]      <= ST_WAIT;
                goodie_act[i] <= 1'b0;
                pos_x[i]      <= X_SPAWN;
                wait_cnt[i]   <= WAIT_RESP;
              end else begin
                pos_x[i] <= pos_x[i] - X_STEP;
                if (dir_up[i]) begin
                  if (pos_y[i] < Y_LO_TURN) begin
                    pos_y[i]  <= Y_LO;
                    dir_up[i] <= 1'b0;
                  end else begin
                    pos_y[i] <= pos_y[i] - Y_STEP;
                  end
                end else begin
                  if (pos_y[i] > Y_HI_TURN) begin
                    pos_y[i]  <= Y_HI;
                    dir_up[i] <= 1'b1;
                  end else begin
                    pos_y[i] <= pos_y[i] + Y_STEP;
                  end
                end
              end
            end
          end
          ST_HIT: begin
            if (tick) begin
              if (wait_cnt[i] == WAIT_ONE) begin
                state[i]    <= ST_WAIT;
                pos_x[i]    <= X_SPAWN;
                wait_cnt[i] <= WAIT_RESP;
              end else begin
                wait_cnt[i] <= wait_cnt[i] - WAIT_ONE;
              end
            end
          end
          default: begin
            state[i]      <= ST_WAIT;
            goodie_act[i] <= 1'b0;
            pos_x[i]      <= X_SPAWN;
            wait_cnt[i]   <= WAIT_RESP;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_GOODIES; g++) begin : g_out
    assign goodie_x[11*g +: 11] = pos_x[g];
    assign goodie_y[10*g +: 10] = pos_y[g];
  end

endmodule

// File: tb/tb_goodie_field.sv
// Directed bench for goodie_field: spawn timing, full scroll, bounce reversals,
// collection, freeze and mid-run reinitialisation.
module tb_goodie_field;

  logic        clk;
  logic        initialize;
  logic        enable;
  logic [1:0]  collect;
  logic [21:0] goodie_x;
  logic [19:0] goodie_y;
  logic [1:0]  goodie_act;
  logic        score_inc;

  logic [0:0]  collect_b;
  logic [10:0] goodie_x_b;
  logic [9:0]  goodie_y_b;
  logic [0:0]  goodie_act_b;
  logic        score_inc_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Narrow band (Y 40..43) so both vertical reversals occur within a few ticks.
  int yb_seq [8] = '{42, 43, 41, 40, 42, 43, 41, 40};

  goodie_field #(
    .NUM_GOODIES(2), .TICK_DIV(4), .STAGGER_TICKS(3), .RESPAWN_TICKS(2), .HIT_TICKS(2)
  ) dut (
    .clk(clk), .initialize(initialize), .enable(enable), .collect(collect),
    .goodie_x(goodie_x), .goodie_y(goodie_y), .goodie_act(goodie_act), .score_inc(score_inc)
  );

  goodie_field #(
    .NUM_GOODIES(1), .TICK_DIV(4), .STAGGER_TICKS(3), .RESPAWN_TICKS(2), .HIT_TICKS(2),
    .Y_SPAN_LOG2(2)
  ) dut_b (
    .clk(clk), .initialize(initialize), .enable(enable), .collect(collect_b),
    .goodie_x(goodie_x_b), .goodie_y(goodie_y_b), .goodie_act(goodie_act_b),
    .score_inc(score_inc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  // Slot 0 spawns at y=196 heading down; it clamps to 295 on move 50 and then climbs.
  function automatic int y0_exp(input int m);
    if (m <= 49) return 196 + 2 * m;
    else if (m == 50) return 295;
    else return 295 - 2 * (m - 50);
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_act"}, 32'(goodie_act), 32'd0);
    check_eq({tag, "_x0"}, 32'(goodie_x[10:0]), 32'd640);
    check_eq({tag, "_x1"}, 32'(goodie_x[21:11]), 32'd640);
    check_eq({tag, "_y0"}, 32'(goodie_y[9:0]), 32'd40);
    check_eq({tag, "_y1"}, 32'(goodie_y[19:10]), 32'd40);
    check_eq({tag, "_score"}, 32'(score_inc), 32'd0);
    check_eq({tag, "_act_b"}, 32'(goodie_act_b), 32'd0);
  endtask

  initial begin
    initialize = 1'b1;
    enable     = 1'b0;
    collect    = 2'b00;
    collect_b  = 1'b0;
    step(2);
    check_reset_state("reset");

    initialize = 1'b0;
    enable     = 1'b1;
    cyc        = 0;
    step(3);
    check_eq("act0_pre_tick", 32'(goodie_act[0]), 32'd0);
    step(1);
    check_eq("spawn_act0", 32'(goodie_act[0]), 32'd1);
    check_eq("spawn_x0", 32'(goodie_x[10:0]), 32'd640);
    check_eq("spawn_y0", 32'(goodie_y[9:0]), 32'd196);
    check_eq("spawn_act_b", 32'(goodie_act_b), 32'd1);
    check_eq("spawn_y_b", 32'(goodie_y_b), 32'd40);

    for (int m = 1; m <= 128; m++) begin
      if (m == 3) begin
        step(3);
        check_eq("act1_pre_spawn", 32'(goodie_act[1]), 32'd0);
        step(1);
        check_eq("act1_spawn", 32'(goodie_act[1]), 32'd1);
        check_eq("x1_spawn", 32'(goodie_x[21:11]), 32'd640);
      end else begin
        step(4);
      end
      check_eq("x0_scroll", 32'(goodie_x[10:0]), 32'(640 - 5 * m));
      check_eq("y0_bob", 32'(goodie_y[9:0]), 32'(y0_exp(m)));
      if (m <= 8) check_eq("y_b_bounce", 32'(goodie_y_b), 32'(yb_seq[m-1]));
    end

    step(4);
    check_eq("exit_act0", 32'(goodie_act[0]), 32'd0);
    check_eq("exit_x0", 32'(goodie_x[10:0]), 32'd640);
    step(4);
    check_eq("respawn_wait_act0", 32'(goodie_act[0]), 32'd0);
    step(4);
    check_eq("respawn_act0", 32'(goodie_act[0]), 32'd1);
    check_eq("respawn_x0", 32'(goodie_x[10:0]), 32'd640);
    check_eq("respawn_y0_range",
             32'((goodie_y[9:0] >= 10'd40) && (goodie_y[9:0] <= 10'd295)), 32'd1);
    check_eq("x1_at_zero", 32'(goodie_x[21:11]), 32'd0);
    step(4);
    check_eq("x0_after_respawn", 32'(goodie_x[10:0]), 32'd635);
    check_eq("exit_act1", 32'(goodie_act[1]), 32'd0);
    check_eq("exit_x1", 32'(goodie_x[21:11]), 32'd640);

    step(1);
    collect = 2'b01;
    step(1);
    check_eq("collect_score", 32'(score_inc), 32'd1);
    check_eq("collect_act0", 32'(goodie_act[0]), 32'd0);
    check_eq("collect_x0", 32'(goodie_x[10:0]), 32'd635);
    collect = 2'b10;
    step(1);
    check_eq("wait_collect_score", 32'(score_inc), 32'd0);
    check_eq("wait_collect_act1", 32'(goodie_act[1]), 32'd0);
    collect = 2'b00;
    step(1);
    check_eq("score_single_pulse", 32'(score_inc), 32'd0);
    step(3);
    check_eq("hit_frozen_x0", 32'(goodie_x[10:0]), 32'd635);
    check_eq("hit_act0", 32'(goodie_act[0]), 32'd0);
    step(1);
    check_eq("hit_done_x0", 32'(goodie_x[10:0]), 32'd640);
    check_eq("hit_done_act0", 32'(goodie_act[0]), 32'd0);
    check_eq("respawn_act1", 32'(goodie_act[1]), 32'd1);
    check_eq("respawn_x1", 32'(goodie_x[21:11]), 32'd640);
    step(4);
    check_eq("post_hit_wait_act0", 32'(goodie_act[0]), 32'd0);
    check_eq("x1_step1", 32'(goodie_x[21:11]), 32'd635);
    step(4);
    check_eq("post_hit_respawn_act0", 32'(goodie_act[0]), 32'd1);
    check_eq("post_hit_respawn_x0", 32'(goodie_x[10:0]), 32'd640);
    check_eq("x1_step2", 32'(goodie_x[21:11]), 32'd630);

    step(3);
    collect = 2'b01;
    step(1);
    check_eq("tick_collect_act0", 32'(goodie_act[0]), 32'd0);
    check_eq("tick_collect_x0", 32'(goodie_x[10:0]), 32'd640);
    check_eq("tick_collect_score", 32'(score_inc), 32'd1);
    check_eq("x1_step3", 32'(goodie_x[21:11]), 32'd625);
    collect = 2'b00;
    step(1);
    check_eq("tick_collect_score_end", 32'(score_inc), 32'd0);

    enable = 1'b0;
    step(50);
    check_eq("freeze_act", 32'(goodie_act), 32'd2);
    check_eq("freeze_x0", 32'(goodie_x[10:0]), 32'd640);
    check_eq("freeze_x1", 32'(goodie_x[21:11]), 32'd625);
    check_eq("freeze_score", 32'(score_inc), 32'd0);
    enable = 1'b1;
    step(2);
    check_eq("thaw_x1_hold", 32'(goodie_x[21:11]), 32'd625);
    step(1);
    check_eq("thaw_x1_move", 32'(goodie_x[21:11]), 32'd620);

    initialize = 1'b1;
    step(1);
    check_reset_state("reinit");
    initialize = 1'b0;
    step(3);
    check_eq("reinit_act0_pre_tick", 32'(goodie_act[0]), 32'd0);
    step(1);
    check_eq("reinit_spawn_act0", 32'(goodie_act[0]), 32'd1);
    check_eq("reinit_spawn_y0", 32'(goodie_y[9:0]), 32'd196);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
